// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over the ihit handshake and
// sequences FETCH -> EXEC -> (retire) FETCH, or EXEC -> HALTED on halt.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [1:0]  PC_src,
    input  logic        PC_EN,
    input  logic        halt,
    input  logic [31:0] rs_data,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {StFetch, StExec, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_off    = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (PC_src)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = branch_target;
            2'b10: next_pc = jump_target;
            2'b11: next_pc = rs_data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            StFetch: begin
                if (ihit) begin
                    ir_d    = iload;
                    state_d = StExec;
                end
            end
            StExec: begin
                // halt wins over a simultaneous retire: the PC stays on the halt.
                if (halt) begin
                    state_d = StHalted;
                end else if (PC_EN) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = StFetch;
                end
            end
            StHalted: begin
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StFetch;
            pc_q      <= PC_INIT;
            ir_q      <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign imemREN  = (state_q == StFetch) && !RST;
    assign imemaddr = pc_q;
    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign instr    = ir_q;
    assign halted   = (state_q == StHalted);
    assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch, exec and
// halt snapshots; a negedge monitor pops them as the DUT enters each phase.
module tb_fetch_unit;

    localparam logic [31:0] PcInit = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [1:0]  PC_src = 2'b00;
    logic        PC_EN = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] retired;

    fetch_unit #(.PC_INIT(PcInit)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .iload    (iload),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .PC_src   (PC_src),
        .PC_EN    (PC_EN),
        .halt     (halt),
        .rs_data  (rs_data),
        .opcode   (opcode),
        .funct    (funct),
        .instr    (instr),
        .pc_plus4 (pc_plus4),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic [5:0]  op;
        logic [5:0]  fn;
    } exp_t;

    exp_t fetch_q[$];
    exp_t exec_q[$];
    exp_t halt_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t cur_f, cur_e, cur_h;
        bit f_act, e_act, h_act, rst_prev;
        f_act = 0; e_act = 0; h_act = 0; rst_prev = 0;
        cur_f = '{default: '0}; cur_e = '{default: '0}; cur_h = '{default: '0};
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rst_ren", {31'b0, imemREN}, 32'd0);
                if (rst_prev) begin
                    chk("rst_instr", instr, 32'h0);
                    chk("rst_opfn", {20'b0, opcode, funct}, 32'h0);
                    chk("rst_pc", imemaddr, PcInit);
                    chk("rst_retired", retired, 32'h0);
                    chk("rst_halted", {31'b0, halted}, 32'd0);
                end
                f_act = 0; e_act = 0; h_act = 0;
            end else if (halted) begin
                f_act = 0; e_act = 0;
                if (!h_act) begin
                    checks++;
                    if (halt_q.size() == 0) begin
                        errors++;
                        $display("FAIL halt_unexpected: got halted=1, expected no halt");
                    end else cur_h = halt_q.pop_front();
                    h_act = 1;
                end
                chk("halt_ren", {31'b0, imemREN}, 32'd0);
                chk("halt_pc", imemaddr, cur_h.addr);
                chk("halt_retired", retired, cur_h.ret);
                chk("halt_instr", instr, cur_h.instr);
            end else if (imemREN) begin
                e_act = 0;
                if (!f_act) begin
                    checks++;
                    if (fetch_q.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_unexpected: got fetch at %h, expected none", imemaddr);
                    end else cur_f = fetch_q.pop_front();
                    f_act = 1;
                end
                chk("fetch_addr", imemaddr, cur_f.addr);
                chk("fetch_retired", retired, cur_f.ret);
            end else begin
                f_act = 0;
                if (!e_act) begin
                    checks++;
                    if (exec_q.size() == 0) begin
                        errors++;
                        $display("FAIL exec_unexpected: got exec of %h, expected none", instr);
                    end else cur_e = exec_q.pop_front();
                    e_act = 1;
                end
                chk("exec_instr", instr, cur_e.instr);
                chk("exec_opcode", {26'b0, opcode}, {26'b0, cur_e.op});
                chk("exec_funct", {26'b0, funct}, {26'b0, cur_e.fn});
                chk("exec_pc_plus4", pc_plus4, cur_e.pp4);
                chk("exec_retired", retired, cur_e.ret);
            end
            rst_prev = RST;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_fetch(input logic [31:0] addr, input logic [31:0] ret);
        exp_t e;
        e = '{default: '0};
        e.addr = addr;
        e.ret  = ret;
        fetch_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] word, input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] pp4, input logic [31:0] ret, input int stall);
        exp_t e;
        e = '{default: '0};
        e.instr = word; e.op = op; e.fn = fn; e.pp4 = pp4; e.ret = ret;
        exec_q.push_back(e);
        ihit  = 1'b0;
        iload = 32'hBAD0_BAD0;
        repeat (stall) cyc();
        ihit  = 1'b1;
        iload = word;
        cyc();
        ihit  = 1'b0;
        iload = 32'hBAD0_BAD0;
    endtask

    // Stall cycles also pulse ihit, which EXEC must ignore.
    task automatic do_retire(input logic [1:0] src, input logic [31:0] rs, input int en_stall,
                             input logic [31:0] next_addr, input logic [31:0] next_ret);
        PC_src  = src;
        rs_data = rs;
        PC_EN   = 1'b0;
        for (int i = 0; i < en_stall; i++) begin
            ihit = 1'b1;
            cyc();
            ihit = 1'b0;
        end
        exp_fetch(next_addr, next_ret);
        PC_EN = 1'b1;
        cyc();
        PC_EN = 1'b0;
    endtask

    task automatic do_halt(input logic [31:0] addr, input logic [31:0] ret,
                           input logic [31:0] word);
        exp_t e;
        e = '{default: '0};
        e.addr = addr; e.ret = ret; e.instr = word;
        halt_q.push_back(e);
        halt    = 1'b1;
        PC_EN   = 1'b1;
        PC_src  = 2'b11;
        rs_data = 32'h1234_5678;
        cyc();
        halt  = 1'b0;
        PC_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ihit  = 1'b1;
            PC_EN = 1'b1;
            iload = 32'hFFFF_0000;
            cyc();
            ihit  = 1'b0;
            PC_EN = 1'b0;
            cyc();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        ihit  = 1'b0;
        PC_EN = 1'b0;
        halt  = 1'b0;
        cyc();
        cyc();
        exp_fetch(PcInit, 32'd0);
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        do_fetch(32'h2008_0005, 6'h08, 6'h05, 32'h0000_0004, 32'd0, 0);
        do_retire(2'b00, 32'h0, 0, 32'h0000_0004, 32'd1);
        do_fetch(32'h0800_0010, 6'h02, 6'h10, 32'h0000_0008, 32'd1, 0);
        do_retire(2'b10, 32'h0, 0, 32'h0000_0040, 32'd2);
        do_fetch(32'h1000_FFFE, 6'h04, 6'h3E, 32'h0000_0044, 32'd2, 3);
        do_retire(2'b01, 32'h0, 0, 32'h0000_003C, 32'd3);
        do_fetch(32'h03E0_0008, 6'h00, 6'h08, 32'h0000_0040, 32'd3, 0);
        do_retire(2'b11, 32'h0000_0040, 0, 32'h0000_0040, 32'd4);
        do_fetch(32'h1000_0003, 6'h04, 6'h03, 32'h0000_0044, 32'd4, 0);
        do_retire(2'b01, 32'h0, 4, 32'h0000_0050, 32'd5);
        do_fetch(32'h03E0_0008, 6'h00, 6'h08, 32'h0000_0054, 32'd5, 0);
        do_retire(2'b11, 32'h1000_0008, 0, 32'h1000_0008, 32'd6);
        do_fetch(32'h0800_0010, 6'h02, 6'h10, 32'h1000_000C, 32'd6, 0);
        do_retire(2'b10, 32'h0, 0, 32'h1000_0040, 32'd7);
        do_fetch(32'h03E0_0008, 6'h00, 6'h08, 32'h1000_0044, 32'd7, 0);
        do_retire(2'b11, 32'h0000_0ABC, 0, 32'h0000_0ABC, 32'd8);
        do_fetch(32'h03E0_0008, 6'h00, 6'h08, 32'h0000_0AC0, 32'd8, 1);
        do_retire(2'b11, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'd9);
        do_fetch(32'h0000_0000, 6'h00, 6'h00, 32'h0000_0000, 32'd9, 0);
        do_retire(2'b00, 32'h0, 0, 32'h0000_0000, 32'd10);
        do_fetch(32'h0000_000C, 6'h00, 6'h0C, 32'h0000_0004, 32'd10, 0);
        do_halt(32'h0000_0000, 32'd10, 32'h0000_000C);
        do_reset();
        do_fetch(32'h2008_0005, 6'h08, 6'h05, 32'h0000_0004, 32'd0, 0);
        do_retire(2'b00, 32'h0, 0, 32'h0000_0004, 32'd1);
        cyc();
        // Reset lands on the same edge as an ihit in FETCH.
        ihit  = 1'b1;
        iload = 32'hDEAD_BEEF;
        do_reset();
        do_fetch(32'h2008_0005, 6'h08, 6'h05, 32'h0000_0004, 32'd0, 1);
        do_retire(2'b00, 32'h0, 0, 32'h0000_0004, 32'd1);
        repeat (3) cyc();
        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        chk("exec_q_drained", exec_q.size(), 32'd0);
        chk("halt_q_drained", halt_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
